mdio_phy_responder: RTL and testbench

Clause-22 MDIO management responder: the PHY end of the MDC/MDIO interface that the TSE MAC drives as master. It decodes read and write frames addressed to its PHY address, serves a 32 x 16-bit register bank, and drives read data back on MDIO with the open-drain enable convention. It sits in fabric behind the board MDIO pins and serves as an emulated PHY in loopback and bring-up builds.

---
 rtl/mdio_pkg.sv | 30 +++
 rtl/mdio_edge_sync.sv | 46 ++++
 rtl/mdio_phy_responder.sv | 254 +++++++++++++++++++++++++
 tb/tb_mdio_phy_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO PHY responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_RDATA,
        S_WDATA
    } mdio_state_t;

    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] OP_WR = 2'b01;

    localparam int PREAMBLE_LEN = 32;

    localparam logic [4:0] REG_CTRL = 5'd0;
    localparam logic [4:0] REG_STAT = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;

    // Status and ID registers are served from live inputs/constants, never the bank.
    function automatic logic is_read_only(input logic [4:0] addr);
        return (addr == REG_STAT) || (addr == REG_ID1) || (addr == REG_ID2);
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronizers for mdc and mdio_in plus the MDC rising-edge detector.
// mdc_rise and mdio_bit come from the same synchronizer depth, so they are cycle-aligned.
module mdio_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic mdc,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdio_bit
);

    logic [1:0] pad_in;
    logic [1:0] pad_sync;
    logic       mdc_prev_reg;

    assign pad_in = {mdio_in, mdc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] sync_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[0], pad_in[gi]};
                end
            end

            assign pad_sync[gi] = sync_reg[1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdc_prev_reg <= 1'b0;
        end else begin
            mdc_prev_reg <= pad_sync[0];
        end
    end

    assign mdc_rise = pad_sync[0] & ~mdc_prev_reg;
    assign mdio_bit = pad_sync[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY responder: decodes frames, serves a 32x16 register bank, drives read data.
// Optional MDIO_BCAST_EN: also accept PHY address 0 for write frames.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR     = 5'd1,
    parameter logic [31:0] PHY_ID       = 32'h0141_0CC2,
    parameter logic [15:0] CTRL_RST_VAL = 16'h1140
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic [15:0] status_i,
    output logic [15:0] ctrl_o,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_LEN);

    logic mdc_rise;
    logic mdio_bit;

    mdio_edge_sync u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdc_rise (mdc_rise),
        .mdio_bit (mdio_bit)
    );

    mdio_state_t state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [5:0]  pre_cnt_reg, pre_cnt_next;
    logic [15:0] shift_reg, shift_next;
    logic [1:0]  op_reg, op_next;
    logic [4:0]  addr_reg, addr_next;
    logic        is_rd_reg, is_rd_next;
    logic        mdio_out_reg, mdio_out_next;
    logic        mdio_oen_reg, mdio_oen_next;
    logic        wr_strobe_reg, wr_strobe_next;
    logic [4:0]  wr_addr_reg, wr_addr_next;
    logic [15:0] wr_data_reg, wr_data_next;
    logic [15:0] ctrl_reg;
    logic [15:0] bank_reg [0:31];
    logic        ctrl_we;
    logic        bank_we;

    logic [1:0]  op_shift;
    logic [4:0]  addr_shift;
    logic [15:0] word_shift;
    logic [15:0] read_word;
    logic        phy_match;

    assign op_shift   = {op_reg[0], mdio_bit};
    assign addr_shift = {addr_reg[3:0], mdio_bit};
    assign word_shift = {shift_reg[14:0], mdio_bit};

`ifdef MDIO_BCAST_EN
    assign phy_match = (addr_shift == PHY_ADDR) || ((addr_shift == 5'd0) && !is_rd_reg);
`else
    assign phy_match = (addr_shift == PHY_ADDR);
`endif

    always_comb begin
        read_word = bank_reg[addr_shift];
        case (addr_shift)
            REG_CTRL: read_word = ctrl_reg;
            REG_STAT: read_word = status_i;
            REG_ID1:  read_word = PHY_ID[31:16];
            REG_ID2:  read_word = PHY_ID[15:0];
            default:  read_word = bank_reg[addr_shift];
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pre_cnt_next   = pre_cnt_reg;
        shift_next     = shift_reg;
        op_next        = op_reg;
        addr_next      = addr_reg;
        is_rd_next     = is_rd_reg;
        mdio_out_next  = mdio_out_reg;
        mdio_oen_next  = mdio_oen_reg;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        ctrl_we        = 1'b0;
        bank_we        = 1'b0;

        if (mdc_rise) begin
            case (state_reg)
                S_IDLE: begin
                    if (mdio_bit) begin
                        if (pre_cnt_reg != PRE_MAX) pre_cnt_next = pre_cnt_reg + 6'd1;
                    end else begin
                        pre_cnt_next = '0;
                        if (pre_cnt_reg == PRE_MAX) state_next = S_ST;
                    end
                end
                S_ST: begin
                    cnt_next   = '0;
                    state_next = mdio_bit ? S_OP : S_IDLE;
                end
                S_OP: begin
                    op_next = op_shift;
                    if (cnt_reg == 4'd0) begin
                        cnt_next = 4'd1;
                    end else begin
                        cnt_next = '0;
                        if (op_shift == OP_RD) begin
                            is_rd_next = 1'b1;
                            state_next = S_PHYAD;
                        end else if (op_shift == OP_WR) begin
                            is_rd_next = 1'b0;
                            state_next = S_PHYAD;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                end
                S_PHYAD: begin
                    addr_next = addr_shift;
                    if (cnt_reg == 4'd4) begin
                        cnt_next   = '0;
                        state_next = phy_match ? S_REGAD : S_IDLE;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                S_REGAD: begin
                    addr_next = addr_shift;
                    if (cnt_reg == 4'd4) begin
                        cnt_next   = '0;
                        state_next = S_TA;
                        // Snapshot the read word now so later status_i changes cannot tear the frame.
                        if (is_rd_reg) shift_next = read_word;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                S_TA: begin
                    if (cnt_reg == 4'd0) begin
                        cnt_next = 4'd1;
                        if (is_rd_reg) begin
                            mdio_oen_next = 1'b0;
                            mdio_out_next = 1'b0;
                        end
                    end else begin
                        cnt_next = '0;
                        if (is_rd_reg) begin
                            mdio_out_next = shift_reg[15];
                            shift_next    = {shift_reg[14:0], 1'b0};
                            state_next    = S_RDATA;
                        end else begin
                            state_next = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (cnt_reg == 4'd15) begin
                        cnt_next      = '0;
                        mdio_oen_next = 1'b1;
                        mdio_out_next = 1'b0;
                        state_next    = S_IDLE;
                    end else begin
                        cnt_next      = cnt_reg + 4'd1;
                        mdio_out_next = shift_reg[15];
                        shift_next    = {shift_reg[14:0], 1'b0};
                    end
                end
                S_WDATA: begin
                    shift_next = word_shift;
                    if (cnt_reg == 4'd15) begin
                        cnt_next       = '0;
                        wr_strobe_next = 1'b1;
                        wr_addr_next   = addr_reg;
                        wr_data_next   = word_shift;
                        ctrl_we        = (addr_reg == REG_CTRL);
                        bank_we        = (addr_reg != REG_CTRL) && !is_read_only(addr_reg);
                        state_next     = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            pre_cnt_reg   <= '0;
            shift_reg     <= '0;
            op_reg        <= '0;
            addr_reg      <= '0;
            is_rd_reg     <= 1'b0;
            mdio_out_reg  <= 1'b0;
            mdio_oen_reg  <= 1'b1;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pre_cnt_reg   <= pre_cnt_next;
            shift_reg     <= shift_next;
            op_reg        <= op_next;
            addr_reg      <= addr_next;
            is_rd_reg     <= is_rd_next;
            mdio_out_reg  <= mdio_out_next;
            mdio_oen_reg  <= mdio_oen_next;
            wr_strobe_reg <= wr_strobe_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
        end
    end

    // Bit 15 (soft reset) self-clears by reloading the whole register on the next clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_reg <= CTRL_RST_VAL;
        end else if (ctrl_we) begin
            ctrl_reg <= word_shift;
        end else if (ctrl_reg[15]) begin
            ctrl_reg <= CTRL_RST_VAL;
        end
    end

    // Flop-based bank: every entry needs a defined reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) bank_reg[i] <= '0;
        end else if (bank_we) begin
            bank_reg[addr_reg] <= word_shift;
        end
    end

    assign mdio_out  = mdio_out_reg;
    assign mdio_oen  = mdio_oen_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign ctrl_o    = ctrl_reg;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed, table-driven bench for mdio_phy_responder acting as an MDIO master with a pulled-up pad.
module tb_mdio_phy_responder;

    localparam time HALF = 60ns;

`ifdef MDIO_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mdc = 1'b0;
    logic        master_en = 1'b1;
    logic        master_bit = 1'b1;
    logic [15:0] status_i = 16'h796D;
    logic        mdio_in;
    logic        mdio_out;
    logic        mdio_oen;
    logic [15:0] ctrl_o;
    logic        wr_strobe;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int          checks = 0;
    int          errors = 0;
    logic        drive_seen = 1'b0;
    int          strobe_cnt = 0;
    logic [15:0] ctrl_at_strobe = '0;
    logic [15:0] ctrl_after = '0;
    logic        after_pend = 1'b0;

    // Pad: master drives when enabled, otherwise the DUT or the pull-up.
    assign mdio_in = master_en ? master_bit : (mdio_oen ? 1'b1 : mdio_out);

    always #5ns clk = ~clk;

    mdio_phy_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .mdc       (mdc),
        .mdio_in   (mdio_in),
        .mdio_out  (mdio_out),
        .mdio_oen  (mdio_oen),
        .status_i  (status_i),
        .ctrl_o    (ctrl_o),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always @(negedge clk) begin
        if (!mdio_oen) drive_seen = 1'b1;
        if (wr_strobe) begin
            strobe_cnt     = strobe_cnt + 1;
            ctrl_at_strobe = ctrl_o;
            after_pend     = 1'b1;
        end else if (after_pend) begin
            ctrl_after = ctrl_o;
            after_pend = 1'b0;
        end
    end

    typedef struct {
        bit          rd;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        int          pre;
        bit          ack;
        logic [15:0] exp;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        master_en  = 1'b1;
        master_bit = b;
        #(HALF);
        mdc = 1'b1;
        #(HALF);
        mdc = 1'b0;
    endtask

    task automatic recv_bit(output logic pad, output logic oen);
        master_en = 1'b0;
        #(HALF);
        pad = mdio_in;
        oen = mdio_oen;
        mdc = 1'b1;
        #(HALF);
        mdc = 1'b0;
    endtask

    task automatic abort_read();
        master_en = 1'b0;
        #23ns;
        chk("abort_driving_d8", {31'd0, mdio_oen}, 32'd0);
        reset_n = 1'b0;
        #1ns;
        chk("abort_oen", {31'd0, mdio_oen}, 32'd1);
        chk("abort_out", {31'd0, mdio_out}, 32'd0);
        #36ns;
        repeat (3) @(negedge clk);
        reset_n    = 1'b1;
        master_en  = 1'b1;
        master_bit = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_frame(input bit rd, input logic [4:0] phy, input logic [4:0] regad,
                             input logic [15:0] wdata, input int pre, input int abort_at,
                             output logic [15:0] rdata, output logic ta_rel,
                             output logic ta_zero, output logic end_rel);
        logic p, o;
        rdata   = '0;
        ta_rel  = 1'b0;
        ta_zero = 1'b0;
        end_rel = 1'b0;
        @(negedge clk);
        drive_seen = 1'b0;
        strobe_cnt = 0;
        send_bit(1'b0);
        repeat (pre) send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(rd);
        send_bit(!rd);
        for (int i = 4; i >= 0; i--) send_bit(phy[i]);
        for (int i = 4; i >= 0; i--) send_bit(regad[i]);
        if (!rd) begin
            send_bit(1'b1);
            send_bit(1'b0);
            for (int i = 15; i >= 0; i--) send_bit(wdata[i]);
        end else begin
            recv_bit(p, o);
            ta_rel = p & o;
            recv_bit(p, o);
            ta_zero = !p && !o;
            for (int i = 15; i >= 0; i--) begin
                if (i == abort_at) begin
                    abort_read();
                    return;
                end
                recv_bit(p, o);
                rdata[i] = p;
            end
            end_rel = mdio_oen;
        end
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic check_read(input string tag, input logic [15:0] exp, input logic [15:0] rdata,
                              input logic ta_rel, input logic ta_zero, input logic end_rel);
        chk({tag, "_ta1_released"}, {31'd0, ta_rel}, 32'd1);
        chk({tag, "_ta2_zero"}, {31'd0, ta_zero}, 32'd1);
        chk({tag, "_rdata"}, {16'd0, rdata}, {16'd0, exp});
        chk({tag, "_released_after_d0"}, {31'd0, end_rel}, 32'd1);
    endtask

    initial begin
        logic [15:0] rdata;
        logic        ta_rel, ta_zero, end_rel;

        vecs[0]  = '{1'b0, 5'd1, 5'd5,  16'hABCD, 32, 1'b1, 16'h0000};
        vecs[1]  = '{1'b1, 5'd1, 5'd5,  16'h0000, 32, 1'b1, 16'hABCD};
        vecs[2]  = '{1'b1, 5'd1, 5'd2,  16'h0000, 32, 1'b1, 16'h0141};
        vecs[3]  = '{1'b1, 5'd1, 5'd3,  16'h0000, 32, 1'b1, 16'h0CC2};
        vecs[4]  = '{1'b0, 5'd7, 5'd6,  16'h1234, 32, 1'b0, 16'h0000};
        vecs[5]  = '{1'b1, 5'd7, 5'd5,  16'h0000, 32, 1'b0, 16'h0000};
        vecs[6]  = '{1'b0, 5'd1, 5'd6,  16'h5555, 31, 1'b0, 16'h0000};
        vecs[7]  = '{1'b1, 5'd1, 5'd6,  16'h0000, 32, 1'b1, 16'h0000};
        vecs[8]  = '{1'b1, 5'd1, 5'd1,  16'h0000, 32, 1'b1, 16'h796D};
        vecs[9]  = '{1'b0, 5'd1, 5'd2,  16'hFFFF, 32, 1'b1, 16'h0000};
        vecs[10] = '{1'b1, 5'd1, 5'd2,  16'h0000, 32, 1'b1, 16'h0141};
        vecs[11] = '{1'b0, 5'd1, 5'd31, 16'h8001, 32, 1'b1, 16'h0000};
        vecs[12] = '{1'b1, 5'd1, 5'd31, 16'h0000, 32, 1'b1, 16'h8001};
        vecs[13] = '{1'b1, 5'd1, 5'd0,  16'h0000, 32, 1'b1, 16'h1140};
        vecs[14] = '{1'b0, 5'd1, 5'd0,  16'h1000, 32, 1'b1, 16'h0000};
        vecs[15] = '{1'b1, 5'd1, 5'd0,  16'h0000, 32, 1'b1, 16'h1000};
        vecs[16] = '{1'b0, 5'd0, 5'd4,  16'h0001, 32, BCAST, 16'h0000};
        vecs[17] = '{1'b1, 5'd0, 5'd4,  16'h0000, 32, 1'b0, 16'h0000};
        vecs[18] = '{1'b1, 5'd1, 5'd4,  16'h0000, 32, 1'b1, {15'd0, BCAST}};

        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_oen", {31'd0, mdio_oen}, 32'd1);
        chk("reset_out", {31'd0, mdio_out}, 32'd0);
        chk("reset_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("reset_wr_addr", {27'd0, wr_addr}, 32'd0);
        chk("reset_wr_data", {16'd0, wr_data}, 32'd0);
        chk("reset_ctrl", {16'd0, ctrl_o}, 32'h1140);

        for (int k = 0; k < NVEC; k++) begin
            run_frame(vecs[k].rd, vecs[k].phy, vecs[k].regad, vecs[k].wdata, vecs[k].pre, -1,
                      rdata, ta_rel, ta_zero, end_rel);
            $display("vec %0d: %s phy=%0d reg=%0d pre=%0d wdata=%h rdata=%h strobes=%0d drive=%0b",
                     k, vecs[k].rd ? "RD" : "WR", vecs[k].phy, vecs[k].regad, vecs[k].pre,
                     vecs[k].wdata, rdata, strobe_cnt, drive_seen);
            if (vecs[k].rd) begin
                if (vecs[k].ack) begin
                    check_read($sformatf("v%0d", k), vecs[k].exp, rdata, ta_rel, ta_zero, end_rel);
                end else begin
                    chk($sformatf("v%0d_no_drive", k), {31'd0, drive_seen}, 32'd0);
                end
            end else begin
                chk($sformatf("v%0d_strobes", k), strobe_cnt, {31'd0, vecs[k].ack});
                chk($sformatf("v%0d_no_drive", k), {31'd0, drive_seen}, 32'd0);
                if (vecs[k].ack) begin
                    chk($sformatf("v%0d_wr_addr", k), {27'd0, wr_addr}, {27'd0, vecs[k].regad});
                    chk($sformatf("v%0d_wr_data", k), {16'd0, wr_data}, {16'd0, vecs[k].wdata});
                end
            end
        end

        // Soft-reset bit: written value visible for one clk, then reload.
        run_frame(1'b0, 5'd1, 5'd0, 16'h9140, 32, -1, rdata, ta_rel, ta_zero, end_rel);
        $display("selfclear: strobes=%0d ctrl_at_strobe=%h ctrl_after=%h", strobe_cnt, ctrl_at_strobe, ctrl_after);
        chk("selfclear_strobes", strobe_cnt, 32'd1);
        chk("selfclear_first_clk", {16'd0, ctrl_at_strobe}, 32'h9140);
        chk("selfclear_next_clk", {16'd0, ctrl_after}, 32'h1140);
        chk("selfclear_settled", {16'd0, ctrl_o}, 32'h1140);

        // Reset in the middle of RDATA bit D8.
        run_frame(1'b1, 5'd1, 5'd5, 16'h0000, 32, 8, rdata, ta_rel, ta_zero, end_rel);
        $display("abort: read reg5 reset during D8, partial=%h", rdata);
        chk("abort_partial_d15_d9", {25'd0, rdata[15:9]}, {25'd0, 7'b1010101});
        chk("abort_ctrl_reset", {16'd0, ctrl_o}, 32'h1140);
        chk("abort_wr_addr_reset", {27'd0, wr_addr}, 32'd0);

        run_frame(1'b1, 5'd1, 5'd3, 16'h0000, 32, -1, rdata, ta_rel, ta_zero, end_rel);
        $display("post-abort: read reg3 rdata=%h", rdata);
        check_read("post_abort_reg3", 16'h0CC2, rdata, ta_rel, ta_zero, end_rel);

        run_frame(1'b1, 5'd1, 5'd5, 16'h0000, 32, -1, rdata, ta_rel, ta_zero, end_rel);
        $display("post-abort: read reg5 rdata=%h", rdata);
        check_read("post_abort_reg5", 16'h0000, rdata, ta_rel, ta_zero, end_rel);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
